freq_sweep_ctrl: RTL and testbench

FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

---
 rtl/freq_pkg.sv | 23 ++
 rtl/freq_timer.sv | 25 ++
 rtl/freq_sweep_ctrl.sv | 159 +++++++++++++++
 tb/tb_freq_sweep_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// Shared state encoding, default frequencies and ADC helpers for the sweep controller.
package freq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_STEP,
    ST_LOCK
  } sweep_state_t;

  localparam logic [19:0] FREQ_START_DEF   = 20'h88B8;
  localparam logic [19:0] FREQ_STOP_DEF    = 20'hAFC8;
  localparam logic [19:0] FREQ_STEP_DEF    = 20'h00032;
  localparam logic [19:0] FREQ_DEFAULT_DEF = 20'h88B8;
  localparam logic [11:0] ADC_MID          = 12'h800;

  // Offset-binary sample folded to distance from the rail it is closest to.
  function automatic logic [11:0] adc_mag(input logic [11:0] d);
    return (d < ADC_MID) ? d : 12'hFFF - d;
  endfunction

endpackage

// File: rtl/freq_timer.sv
// Loadable down-counter shared by settle and re-sweep timing; parks at zero.
module freq_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                        r_cnt <= '0;
    else if (i_clr)                   r_cnt <= '0;
    else if (i_load)                  r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Steps the drive frequency across a band, averages ADC magnitude at every step
// and parks on the frequency with the strongest response.
module freq_sweep_ctrl
  import freq_pkg::*;
#(
  parameter logic [19:0] F_START     = FREQ_START_DEF,
  parameter logic [19:0] F_STOP      = FREQ_STOP_DEF,
  parameter logic [19:0] F_STEP      = FREQ_STEP_DEF,
  parameter logic [19:0] F_DEFAULT   = FREQ_DEFAULT_DEF,
  parameter logic [23:0] SETTLE_CYC  = 24'h30D40,
  parameter int          AVG_LOG2    = 2,
  parameter logic [31:0] RESWEEP_CYC = 32'd0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        swipt_alive,
  input  logic        sweep_req,
  input  logic        adc_valid,
  input  logic [11:0] adc_data,
  output logic [19:0] freq_out,
  output logic        freq_valid,
  output logic        sweep_busy,
  output logic        sweep_done,
  output logic [19:0] best_freq,
  output logic [11:0] best_mag
);

  localparam int               ACC_W      = 12 + AVG_LOG2;
  localparam int               SMP_W      = AVG_LOG2 + 1;
  localparam logic [SMP_W-1:0] LAST_SMP   = SMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [31:0]      SETTLE_LD  = (SETTLE_CYC == '0) ? 32'd0 : {8'd0, SETTLE_CYC} - 32'd1;
  localparam logic [31:0]      RESWEEP_LD = (RESWEEP_CYC == '0) ? 32'd0 : RESWEEP_CYC - 32'd1;

  sweep_state_t     r_state;
  logic [19:0]      r_freq, r_best_freq;
  logic [11:0]      r_best_mag;
  logic [ACC_W-1:0] r_acc;
  logic [SMP_W-1:0] r_smp;
  logic             r_freq_valid, r_busy, r_done;

  logic [ACC_W-1:0] w_sum;
  logic [11:0]      w_avg;
  logic [20:0]      w_next_f;
  logic [19:0]      w_freq_nxt;
  logic [31:0]      w_t_val;
  logic             w_last, w_over, w_tzero, w_restart, w_start, w_t_load, w_t_dec;

  assign w_sum     = r_acc + ACC_W'(adc_mag(adc_data));
  assign w_avg     = 12'(w_sum >> AVG_LOG2);
  assign w_last    = (r_state == ST_SAMPLE) && adc_valid && (r_smp == LAST_SMP);
  assign w_next_f  = {1'b0, r_freq} + {1'b0, F_STEP};
  assign w_over    = w_next_f > {1'b0, F_STOP};
  assign w_restart = (r_state == ST_LOCK) && (sweep_req || (RESWEEP_CYC != '0 && w_tzero));
  assign w_start   = swipt_alive && (((r_state == ST_IDLE) && sweep_req) || w_restart);

  // One timer serves both the per-step settle and the LOCK re-sweep interval.
  always_comb begin
    w_freq_nxt = r_freq;
    w_t_load   = 1'b0;
    w_t_val    = SETTLE_LD;
    w_t_dec    = 1'b0;
    if (!swipt_alive) begin
      w_freq_nxt = F_DEFAULT;
    end else if (w_start) begin
      w_freq_nxt = F_START;
      w_t_load   = 1'b1;
    end else if (r_state == ST_STEP) begin
      w_t_load = 1'b1;
      if (w_over) begin
        w_freq_nxt = r_best_freq;
        w_t_val    = RESWEEP_LD;
      end else begin
        w_freq_nxt = w_next_f[19:0];
      end
    end else begin
      w_t_dec = (r_state == ST_SETTLE) || (r_state == ST_LOCK);
    end
  end

  freq_timer #(.W(32)) u_timer (
    .clk        (clk),
    .nrst       (nrst),
    .i_clr      (!swipt_alive),
    .i_load     (w_t_load),
    .i_load_val (w_t_val),
    .i_dec      (w_t_dec),
    .o_zero     (w_tzero)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= ST_IDLE;
      r_freq       <= F_DEFAULT;
      r_best_freq  <= F_DEFAULT;
      r_best_mag   <= '0;
      r_acc        <= '0;
      r_smp        <= '0;
      r_freq_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_freq       <= w_freq_nxt;
      r_freq_valid <= (w_freq_nxt != r_freq);
      r_done       <= 1'b0;
      if (!swipt_alive) begin
        r_state     <= ST_IDLE;
        r_best_freq <= F_DEFAULT;
        r_best_mag  <= '0;
        r_acc       <= '0;
        r_smp       <= '0;
        r_busy      <= 1'b0;
      end else if (w_start) begin
        r_state     <= ST_SETTLE;
        r_best_freq <= F_START;
        r_best_mag  <= '0;
        r_acc       <= '0;
        r_smp       <= '0;
        r_busy      <= 1'b1;
      end else begin
        case (r_state)
          ST_SETTLE: if (w_tzero) r_state <= ST_SAMPLE;
          ST_SAMPLE: begin
            if (w_last) begin
              r_state <= ST_STEP;
              r_acc   <= '0;
              r_smp   <= '0;
              // Strict compare: on a tie the earlier (lower) frequency wins.
              if (w_avg > r_best_mag) begin
                r_best_mag  <= w_avg;
                r_best_freq <= r_freq;
              end
            end else if (adc_valid) begin
              r_acc <= w_sum;
              r_smp <= r_smp + 1'b1;
            end
          end
          ST_STEP: begin
            if (w_over) begin
              r_state <= ST_LOCK;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_SETTLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign freq_out   = r_freq;
  assign freq_valid = r_freq_valid;
  assign sweep_busy = r_busy;
  assign sweep_done = r_done;
  assign best_freq  = r_best_freq;
  assign best_mag   = r_best_mag;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Randomized bench for freq_sweep_ctrl: a step-by-step sweep model predicts
// drive frequency, busy/done/valid pulses and the best-magnitude result.
module tb_freq_sweep_ctrl;

  localparam logic [19:0] FS   = 20'd100;
  localparam logic [19:0] FE   = 20'd300;
  localparam logic [19:0] FST  = 20'd100;
  localparam logic [19:0] FD   = 20'd100;
  localparam int          SETTLE = 4;
  localparam int          NS     = 2;

  logic        clk = 1'b0, nrst = 1'b0, swipt_alive = 1'b0, sweep_req = 1'b0, adc_valid = 1'b0;
  logic [11:0] adc_data = '0;
  logic [19:0] freq_out, best_freq;
  logic [11:0] best_mag;
  logic        freq_valid, sweep_busy, sweep_done;

  int          n_chk = 0, n_err = 0;
  logic [19:0] cur_f = FD, m_bf = FD;
  logic [11:0] m_bm = '0;
  logic [11:0] dtab [3];

  always #5 clk = ~clk;

  freq_sweep_ctrl #(
    .F_START(FS), .F_STOP(FE), .F_STEP(FST), .F_DEFAULT(FD),
    .SETTLE_CYC(24'd4), .AVG_LOG2(1), .RESWEEP_CYC(32'd10)
  ) dut (
    .clk(clk), .nrst(nrst), .swipt_alive(swipt_alive), .sweep_req(sweep_req),
    .adc_valid(adc_valid), .adc_data(adc_data), .freq_out(freq_out),
    .freq_valid(freq_valid), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .best_freq(best_freq), .best_mag(best_mag)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int mag(input logic [11:0] d);
    return (d < 12'h800) ? int'(d) : 4095 - int'(d);
  endfunction

  function automatic logic [11:0] rnd_adc();
    case ($urandom_range(0, 5))
      0:       return 12'h7FF;
      1:       return 12'h800;
      2:       return 12'h000;
      3:       return 12'hFFF;
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_busy(input string tag, input bit fv);
    chk({tag, ".freq"}, freq_out, cur_f);
    chk({tag, ".busy"}, sweep_busy, 1);
    chk({tag, ".done"}, sweep_done, 0);
    chk({tag, ".fv"}, freq_valid, fv);
  endtask

  task automatic chk_idle(input string tag, input bit fv);
    chk({tag, ".freq"}, freq_out, cur_f);
    chk({tag, ".bf"}, best_freq, m_bf);
    chk({tag, ".bm"}, best_mag, m_bm);
    chk({tag, ".fv"}, freq_valid, fv);
    chk({tag, ".busy"}, sweep_busy, 0);
    chk({tag, ".done"}, sweep_done, 0);
  endtask

  // Settle window: samples offered here must be ignored.
  task automatic settle_ph(input bit fv);
    for (int i = 0; i < SETTLE; i++) begin
      chk_busy("settle", (i == 0) ? fv : 1'b0);
      adc_valid = 1'($urandom);
      adc_data  = 12'($urandom);
      sweep_req = ($urandom_range(0, 5) == 0);
      tick();
    end
  endtask

  // Collect NS valid samples; mode 1 = fixed data every cycle, 2 = fixed data
  // with gaps, 0 = random data with gaps.
  task automatic sample_ph(input int mode, input logic [11:0] dval, output logic [11:0] avg);
    int n = 0, sum = 0, cyc = 0;
    while (n < NS && cyc < 64) begin
      chk_busy("sample", 1'b0);
      adc_valid = (mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
      adc_data  = (mode == 0) ? rnd_adc() : dval;
      sweep_req = ($urandom_range(0, 5) == 0);
      if (adc_valid) begin
        sum += mag(adc_data);
        n++;
      end
      cyc++;
      tick();
    end
    if (n < NS) chk("sample_timeout", n, NS);
    adc_valid = 1'b0;
    avg = 12'(sum / NS);
  endtask

  task automatic step_ph(input logic [11:0] avg, output bit done);
    logic [19:0] prev;
    if (avg > m_bm) begin
      m_bm = avg;
      m_bf = cur_f;
    end
    chk_busy("step", 1'b0);
    chk("step.bm", best_mag, m_bm);
    chk("step.bf", best_freq, m_bf);
    sweep_req = 1'($urandom);
    tick();
    sweep_req = 1'b0;
    if (int'(cur_f) + int'(FST) > int'(FE)) begin
      prev  = cur_f;
      cur_f = m_bf;
      done  = 1'b1;
      chk("lock.freq", freq_out, cur_f);
      chk("lock.fv", freq_valid, cur_f != prev);
      chk("lock.busy", sweep_busy, 0);
      chk("lock.done", sweep_done, 1);
      chk("lock.bf", best_freq, m_bf);
      chk("lock.bm", best_mag, m_bm);
    end else begin
      cur_f = cur_f + FST;
      done  = 1'b0;
    end
  endtask

  task automatic start_sweep(input bit use_req, output bit fv);
    sweep_req = use_req;
    adc_valid = 1'($urandom);
    adc_data  = 12'($urandom);
    tick();
    sweep_req = 1'b0;
    fv    = (cur_f != FS);
    cur_f = FS;
    m_bf  = FS;
    m_bm  = '0;
  endtask

  task automatic full_sweep(input int mode, input bit fv0);
    int s = 0;
    bit d = 1'b0;
    logic [11:0] avg;
    settle_ph(fv0);
    while (!d) begin
      sample_ph(mode, dtab[s], avg);
      step_ph(avg, d);
      s++;
      if (!d) settle_ph(1'b1);
    end
  endtask

  task automatic lock_wait(input int k);
    for (int i = 0; i < k; i++) begin
      sweep_req = 1'b0;
      adc_valid = 1'($urandom);
      adc_data  = 12'($urandom);
      tick();
      chk_idle("lockhold", 1'b0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fv, d;
    logic [11:0] avg;

    repeat (3) tick();
    chk_idle("reset", 1'b0);
    nrst        = 1'b1;
    swipt_alive = 1'b1;
    repeat (3) begin
      tick();
      chk_idle("idle", 1'b0);
    end

    // Peak in the middle of the band.
    dtab = '{12'h900, 12'h780, 12'h700};
    start_sweep(1'b1, fv);
    full_sweep(1, fv);
    chk("peak.bf", best_freq, 200);
    chk("peak.bm", best_mag, 12'h780);
    chk("peak.freq", freq_out, 200);

    // Flat response: tie keeps the lowest frequency.
    lock_wait(3);
    dtab = '{12'h600, 12'h600, 12'h600};
    start_sweep(1'b1, fv);
    full_sweep(1, fv);
    chk("tie.bf", best_freq, 100);
    chk("tie.freq", freq_out, 100);
    chk("tie.bm", best_mag, 12'h600);

    // Automatic re-sweep 10 cycles after done, then random sweeps.
    lock_wait(9);
    start_sweep(1'b0, fv);
    full_sweep(0, fv);
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 3; i++)
        case ($urandom_range(0, 3))
          0: dtab[i] = 12'h600;
          1: dtab[i] = 12'h700;
          2: dtab[i] = 12'h780;
          default: dtab[i] = 12'h900;
        endcase
      if ($urandom_range(0, 1) == 0) begin
        lock_wait(9);
        start_sweep(1'b0, fv);
      end else begin
        lock_wait($urandom_range(0, 8));
        start_sweep(1'b1, fv);
      end
      full_sweep($urandom_range(0, 1) * 2, fv);
    end

    // Link drop during the second settle window.
    lock_wait(2);
    start_sweep(1'b1, fv);
    settle_ph(fv);
    sample_ph(0, 12'h0, avg);
    step_ph(avg, d);
    chk_busy("drop.s0", 1'b1);
    tick();
    chk_busy("drop.s1", 1'b0);
    swipt_alive = 1'b0;
    sweep_req   = 1'b1;
    tick();
    cur_f = FD;
    m_bf  = FD;
    m_bm  = '0;
    chk_idle("drop", 1'b1);
    repeat (3) begin
      tick();
      chk_idle("drop.low", 1'b0);
    end
    swipt_alive = 1'b1;
    sweep_req   = 1'b0;
    repeat (2) begin
      tick();
      chk_idle("drop.up", 1'b0);
    end

    // Async reset while SAMPLE is stalled after one sample.
    start_sweep(1'b1, fv);
    settle_ph(fv);
    chk_busy("rs.s0", 1'b0);
    adc_valid = 1'b1;
    adc_data  = 12'h7FF;
    tick();
    adc_valid = 1'b0;
    repeat (3) begin
      chk_busy("rs.stall", 1'b0);
      tick();
    end
    #2 nrst = 1'b0;
    #1;
    cur_f = FD;
    m_bf  = FD;
    m_bm  = '0;
    chk_idle("rs.async", 1'b0);
    tick();
    tick();
    nrst = 1'b1;
    tick();
    chk_idle("rs.idle", 1'b0);
    dtab = '{12'h100, 12'h200, 12'h050};
    start_sweep(1'b1, fv);
    full_sweep(1, fv);
    chk("rs.bf", best_freq, 200);
    chk("rs.bm", best_mag, 12'h200);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
